// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared types and constants for the instruction-memory loader
package processor_pkg;

    localparam int          LOADER_ADDR_W = 7;
    localparam int          LOADER_DATA_W = 16;
    localparam int          LOADER_DEPTH  = 128;
    localparam logic [7:0]  LOADER_SYNC   = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HI,
        ST_LO,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte stream to instruction-memory writer, holds CPU in reset until verified
module program_loader
    import processor_pkg::*;
#(
    parameter int         ADDR_W    = LOADER_ADDR_W,
    parameter int         DATA_W    = LOADER_DATA_W,
    parameter int         DEPTH     = LOADER_DEPTH,
    parameter logic [7:0] SYNC_BYTE = LOADER_SYNC
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [7:0]        In_data,
    input  logic              In_valid,
    output logic              In_ready,
    output logic              IM_wr,
    output logic [ADDR_W-1:0] IM_addr,
    output logic [DATA_W-1:0] IM_data,
    output logic              Cpu_ResetN,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    loader_state_t     state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   ctr_q, ctr_d;
    logic [7:0]        chk_q, chk_d;
    logic [7:0]        hi_q, hi_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              cpu_resetn_q, cpu_resetn_d;
    logic              accept;

    assign accept = In_valid;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            ctr_q        <= '0;
            chk_q        <= '0;
            hi_q         <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            cpu_resetn_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            ctr_q        <= ctr_d;
            chk_q        <= chk_d;
            hi_q         <= hi_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            cpu_resetn_q <= cpu_resetn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        ctr_d   = ctr_q;
        chk_d   = chk_q;
        hi_d    = hi_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        if (accept) begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (In_data == SYNC_BYTE) state_d = ST_COUNT;
                end
                ST_COUNT: begin
                    if (In_data == 8'd0 || int'(In_data) > DEPTH) begin
                        state_d = ST_ERROR;
                    end else begin
                        n_d     = In_data[ADDR_W:0];
                        ctr_d   = '0;
                        chk_d   = In_data;
                        state_d = ST_HI;
                    end
                end
                ST_HI: begin
                    hi_d    = In_data;
                    chk_d   = chk_q ^ In_data;
                    state_d = ST_LO;
                end
                ST_LO: begin
                    data_d = {hi_q, In_data};
                    addr_d = ctr_q[ADDR_W-1:0];
                    wr_d   = 1'b1;
                    chk_d  = chk_q ^ In_data;
                    // Counter is one bit wider than the address so a full-depth image ends cleanly.
                    if (ctr_q + 1'b1 == n_q) begin
                        state_d = ST_CHECK;
                    end else begin
                        ctr_d   = ctr_q + 1'b1;
                        state_d = ST_HI;
                    end
                end
                ST_CHECK: begin
                    state_d = (In_data == chk_q) ? ST_DONE : ST_ERROR;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        cpu_resetn_d = (state_d == ST_DONE);
    end

    assign In_ready   = 1'b1;
    assign IM_wr      = wr_q;
    assign IM_addr    = addr_q;
    assign IM_data    = data_q;
    assign Cpu_ResetN = cpu_resetn_q;
    assign Busy       = (state_q == ST_COUNT) || (state_q == ST_HI) ||
                        (state_q == ST_LO)    || (state_q == ST_CHECK);
    assign Done       = (state_q == ST_DONE);
    assign Error      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized bench for program_loader against a frame-buffer reference model
module tb_program_loader;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  In_data = 8'h00;
    logic        In_valid = 1'b0;
    logic        In_ready;
    logic        IM_wr;
    logic [6:0]  IM_addr;
    logic [15:0] IM_data;
    logic        Cpu_ResetN;
    logic        Busy;
    logic        Done;
    logic        Error;

    always #5 Clk = ~Clk;

    program_loader dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .In_data    (In_data),
        .In_valid   (In_valid),
        .In_ready   (In_ready),
        .IM_wr      (IM_wr),
        .IM_addr    (IM_addr),
        .IM_data    (IM_data),
        .Cpu_ResetN (Cpu_ResetN),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: buffer every byte after a SYNC and interpret the frame as a whole.
    logic [7:0]  fbuf[$];
    bit          m_in_frame;
    int          m_status;      // 0 none, 1 done, 2 error
    bit          m_wr;
    logic [6:0]  m_addr;
    logic [15:0] m_data;
    logic [15:0] m_mem [128];

    task automatic model_byte(input logic [7:0] b);
        int n, sz;
        logic [7:0] x;
        if (!m_in_frame) begin
            if (b == 8'hA5) begin
                m_in_frame = 1;
                m_status   = 0;
                fbuf.delete();
            end
        end else begin
            fbuf.push_back(b);
            n  = int'(fbuf[0]);
            sz = fbuf.size();
            if (sz == 1 && (n == 0 || n > 128)) begin
                m_in_frame = 0;
                m_status   = 2;
            end else if (sz >= 3 && (sz % 2) == 1 && sz <= 2 * n + 1) begin
                m_wr   = 1;
                m_addr = 7'((sz - 3) / 2);
                m_data = {fbuf[sz-2], fbuf[sz-1]};
                m_mem[m_addr] = m_data;
            end else if (sz == 2 * n + 2) begin
                x = 8'h00;
                for (int i = 0; i < 2 * n + 1; i++) x ^= fbuf[i];
                m_status   = (x == b) ? 1 : 2;
                m_in_frame = 0;
            end
        end
    endtask

    always @(posedge Clk) begin
        m_wr = 0;
        if (Reset) begin
            m_in_frame = 0;
            m_status   = 0;
            m_addr     = '0;
            m_data     = '0;
            fbuf.delete();
        end else if (In_valid) begin
            model_byte(In_data);
        end
    end

    bit          armed = 0;
    int          dut_wr = 0;
    logic [15:0] dut_mem [128];

    always @(negedge Clk) begin
        if (armed) begin
            check("in_ready",   In_ready,   1);
            check("im_wr",      IM_wr,      m_wr);
            check("im_addr",    IM_addr,    m_addr);
            check("im_data",    IM_data,    m_data);
            check("busy",       Busy,       m_in_frame);
            check("done",       Done,       m_status == 1);
            check("error",      Error,      m_status == 2);
            check("cpu_resetn", Cpu_ResetN, m_status == 1);
            if (IM_wr === 1'b1) begin
                dut_mem[IM_addr] = IM_data;
                dut_wr++;
            end
        end
    end

    logic [15:0] wbuf [128];

    task automatic send(input logic [7:0] b, input int maxgap);
        repeat ($urandom_range(0, maxgap)) begin
            In_valid = 1'b0;
            In_data  = 8'($urandom);
            @(negedge Clk);
        end
        In_valid = 1'b1;
        In_data  = b;
        @(negedge Clk);
        In_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit corrupt, input int maxgap);
        logic [7:0] x;
        x = 8'(n);
        send(8'hA5, maxgap);
        send(8'(n), maxgap);
        for (int i = 0; i < n; i++) begin
            send(wbuf[i][15:8], maxgap);
            send(wbuf[i][7:0], maxgap);
            x ^= wbuf[i][15:8] ^ wbuf[i][7:0];
        end
        send(corrupt ? ~x : x, maxgap);
    endtask

    task automatic settle();
        repeat (3) @(negedge Clk);
    endtask

    int w0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check("rst_in_ready", In_ready, 1);
        check("rst_im_wr", IM_wr, 0);
        check("rst_im_addr", IM_addr, 0);
        check("rst_im_data", IM_data, 0);
        check("rst_cpu_resetn", Cpu_ResetN, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_error", Error, 0);
        Reset = 1'b0;
        armed = 1;
        settle();

        // Two-word image
        w0 = dut_wr;
        wbuf[0] = 16'h1234; wbuf[1] = 16'h5000;
        send_frame(2, 0, 0);
        settle();
        check("t1_writes", dut_wr - w0, 2);
        check("t1_mem0", dut_mem[0], 16'h1234);
        check("t1_mem1", dut_mem[1], 16'h5000);
        check("t1_model_mem1", m_mem[1], 16'h5000);
        check("t1_done", Done, 1);
        check("t1_cpu", Cpu_ResetN, 1);

        // Junk before the frame
        w0 = dut_wr;
        send(8'h00, 1); send(8'hFF, 1); send(8'h3C, 1);
        send_frame(2, 0, 1);
        settle();
        check("t2_writes", dut_wr - w0, 2);
        check("t2_mem0", dut_mem[0], 16'h1234);
        check("t2_done", Done, 1);

        // Bad checksum: A5 01 AB CD 00
        w0 = dut_wr;
        send(8'hA5, 0); send(8'h01, 0); send(8'hAB, 0); send(8'hCD, 0); send(8'h00, 0);
        settle();
        check("t3_writes", dut_wr - w0, 1);
        check("t3_mem0", dut_mem[0], 16'hABCD);
        check("t3_error", Error, 1);
        check("t3_cpu", Cpu_ResetN, 0);

        // Illegal counts, then recovery
        w0 = dut_wr;
        send(8'hA5, 0); send(8'h00, 0);
        settle();
        check("t4_err_n0", Error, 1);
        send(8'hA5, 0); send(8'h81, 0);
        settle();
        check("t4_err_n129", Error, 1);
        check("t4_no_writes", dut_wr - w0, 0);
        wbuf[0] = 16'h1234; wbuf[1] = 16'h5000;
        send_frame(2, 0, 0);
        settle();
        check("t4_recover_done", Done, 1);

        // Full-depth image with random valid gaps
        w0 = dut_wr;
        for (int i = 0; i < 128; i++) wbuf[i] = 16'(i);
        send_frame(128, 0, 2);
        settle();
        check("t5_writes", dut_wr - w0, 128);
        for (int i = 0; i < 128; i++) begin
            if (dut_mem[i] !== 16'(i)) check("t5_mem", dut_mem[i], 16'(i));
        end
        check("t5_mem127", dut_mem[127], 16'h007F);
        check("t5_done", Done, 1);
        check("t5_cpu", Cpu_ResetN, 1);

        // Reset mid-frame
        w0 = dut_wr;
        send(8'hA5, 0); send(8'h02, 0); send(8'h12, 0);
        Reset = 1'b1;
        @(negedge Clk);
        check("t6_im_wr", IM_wr, 0);
        check("t6_cpu", Cpu_ResetN, 0);
        check("t6_busy", Busy, 0);
        check("t6_done", Done, 0);
        check("t6_addr", IM_addr, 0);
        check("t6_data", IM_data, 0);
        Reset = 1'b0;
        settle();
        check("t6_no_writes", dut_wr - w0, 0);
        wbuf[0] = 16'h1234; wbuf[1] = 16'h5000;
        send_frame(2, 0, 1);
        settle();
        check("t6_done_after", Done, 1);

        // Randomized frames, SYNC-valued data, corrupt checksums, junk
        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
            if (r % 4 == 0) wbuf[0] = 16'hA5A5;
            repeat ($urandom_range(0, 3)) send(8'($urandom_range(0, 8'hA4)), 2);
            send_frame(n, ($urandom_range(0, 3) == 0), 2);
            settle();
        end

        settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
